uart_rx_os16: RTL

Oversampling UART receiver that sits directly upstream of the top-level command/mode logic. It turns the HC-05 serial line (8N1) into a held command byte plus a one-cycle valid strobe; the top level takes its BCD decode from that byte. Each bit is sampled 16× with a 3-sample majority vote, and false starts are rejected, so a noisy Bluetooth line cannot produce spurious motor commands.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_os16_if.sv | 15 +
 rtl/uart_rx_os16_baud_tick_gen.sv | 31 +++
 rtl/uart_rx_os16.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the oversampling UART receiver
// Purpose: frame geometry (16x oversampling, 3-point sampling window, 8N1 layout)
//          and the receiver state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int         OVERSAMPLE   = 16;
  localparam logic [3:0] LAST_POS     = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMPLE_A     = 4'd7;
  localparam logic [3:0] SAMPLE_B     = 4'd8;
  localparam logic [3:0] SAMPLE_C     = 4'd9;
  // Frame bit index of the last data bit (start is 0, data are 1..8).
  localparam logic [3:0] DATA_BITS    = 4'd8;
  localparam logic [3:0] STOP_BIT_IDX = 4'd9;

endpackage

// File: rtl/uart_rx_os16_if.sv
// rtl/uart_rx_os16_if.sv - serial line and received-byte bundle for uart_rx_os16
// Purpose: groups the raw line and the receiver outputs.
// Signals: rxd (raw line, idles high), rx_data (held byte), rx_valid (1-cycle
//          strobe), frame_err (1-cycle strobe), busy (frame in progress).
// Modports: master = receiver side, slave = line driver / byte consumer.
interface uart_rx_os16_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (input rxd, output rx_data, output rx_valid, output frame_err, output busy);
  modport slave  (output rxd, input rx_data, input rx_valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx_os16_baud_tick_gen.sv
// rtl/uart_rx_os16_baud_tick_gen.sv - oversample tick divider with run enable
// Purpose: counts 0..DIV-1 while en is high and flags the last count as tick.
// Ports: clk, rst (async, active-high), en (run; counter held at 0 when low),
//        tick (high in the cycle the counter equals DIV-1).
module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with majority vote
// Purpose: turns the raw serial line into a held byte plus a valid strobe,
//          rejecting false starts and flagging bad stop bits.
// Ports: clk, rst (async, active-high), bus (uart_rx_os16_if.master:
//        rxd in; rx_data, rx_valid, frame_err, busy out).
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_os16_if.master   bus
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);

  logic       rxd_m, rxd_s, rxd_p;
  state_t     state;
  logic [7:0] n;          // frame tick index: [7:4] bit, [3:0] sample position
  logic [1:0] smp;        // samples taken at positions 7 and 8
  logic [7:0] shreg;
  logic [7:0] rx_data_r;
  logic       rx_valid_r, frame_err_r;
  logic       tick, maj;
  logic [3:0] pos, bidx;

  assign pos  = n[3:0];
  assign bidx = n[7:4];
  // Third vote is the live line value on the position-9 tick.
  assign maj  = (smp[0] & smp[1]) | (smp[0] & rxd_s) | (smp[1] & rxd_s);

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= bus.rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      n           <= '0;
      smp         <= '0;
      shreg       <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (state == IDLE) begin
        // Edge, not level: a line stuck low does not retrigger.
        if (rxd_p && !rxd_s) begin
          state <= START;
          n     <= '0;
        end
      end else if (tick) begin
        n <= n + 8'd1;
        if (pos == SAMPLE_A) smp[0] <= rxd_s;
        if (pos == SAMPLE_B) smp[1] <= rxd_s;
        case (state)
          START: begin
            if (pos == SAMPLE_C && maj) state <= IDLE;
            else if (pos == LAST_POS)   state <= DATA;
          end
          DATA: begin
            if (pos == SAMPLE_C) shreg <= {maj, shreg[7:1]};
            if (pos == LAST_POS && bidx == DATA_BITS) state <= STOP;
          end
          STOP: begin
            // Decide mid stop bit; the rest of it is spent in IDLE so a
            // back-to-back start edge is not missed.
            if (pos == SAMPLE_C && bidx == STOP_BIT_IDX) begin
              if (maj) begin
                rx_data_r  <= shreg;
                rx_valid_r <= 1'b1;
              end else begin
                frame_err_r <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state != IDLE);

endmodule
